// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Hands the address bus and MEMDATA to an external master (debug loader /
//   UART DMA). On request it suppresses instruction fetch, waits for the
//   pipeline to drain, grants the bus, then runs single-byte memory reads and
//   writes over the load/dir/ack handshake. An access that sees no ack within
//   ACK_TIMEOUT cycles is aborted with an error pulse.
// Ports
//   MAINCLK, MAINRST          clock (rising edge), async active-low reset
//   ext_req/ext_grant         bus ownership request / grant
//   ext_valid/ext_ready       transaction handshake (write, addr, wdata)
//   ext_rdata/ext_done/err    completion: read data (held), done and error pulses
//   fetch_suppress            to pipeline: stop fetching
//   addr_oe/addr_out          ADDRBUS drive
//   mem_data_oe/mem_wdata     MEMDATA drive (writes)
//   mem_rdata                 MEMDATA sample (reads)
//   mem_load/mem_dir/mem_ack  memory strobe, direction (1 = memory drives), ack
module mem_bus_arbiter #(
  parameter int DRAIN_CYCLES = 3,   // 1..15
  parameter int ACK_TIMEOUT  = 15   // 1..255
) (
  input  logic        MAINCLK,
  input  logic        MAINRST,
  input  logic        ext_req,
  output logic        ext_grant,
  output logic        ext_ready,
  input  logic        ext_valid,
  input  logic        ext_write,
  input  logic [15:0] ext_addr,
  input  logic [7:0]  ext_wdata,
  output logic [7:0]  ext_rdata,
  output logic        ext_done,
  output logic        ext_err,
  output logic        fetch_suppress,
  output logic        addr_oe,
  output logic [15:0] addr_out,
  output logic        mem_data_oe,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_load,
  output logic        mem_dir,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_CPU, S_DRAIN, S_GRANT, S_ACCESS, S_RELEASE
  } state_e;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;      // drain countdown, then ack-wait count-up
  req_t       req_q, req_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // state register
  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) begin
      state_q <= S_CPU;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_CPU: begin
        if (ext_req) begin
          state_d = S_DRAIN;
          cnt_d   = 8'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        // a dropped request wins over an expiring drain count
        if (!ext_req)          state_d = S_RELEASE;
        else if (cnt_q == '0)  state_d = S_GRANT;
        else                   cnt_d   = cnt_q - 8'd1;
      end
      S_GRANT: begin
        if (ext_req && ext_valid) begin
          req_d   = '{write: ext_write, addr: ext_addr, wdata: ext_wdata};
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else if (!ext_req) begin
          state_d = S_RELEASE;
        end
      end
      S_ACCESS: begin
        // ack on the final allowed edge still counts as success
        if (mem_ack) begin
          if (!req_q.write) rdata_d = mem_rdata;
          done_d  = 1'b1;
          state_d = S_GRANT;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          if (!req_q.write) rdata_d = 8'hFF;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_GRANT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: state_d = S_CPU;
      default:   state_d = S_CPU;
    endcase
  end

  // outputs: decoded from state and latched request only, so no ext_* input
  // reaches the memory-side pins combinationally
  always_comb begin
    fetch_suppress = 1'b0;
    ext_grant      = 1'b0;
    ext_ready      = 1'b0;
    addr_oe        = 1'b0;
    addr_out       = '0;
    mem_load       = 1'b0;
    mem_dir        = 1'b0;
    mem_data_oe    = 1'b0;
    mem_wdata      = '0;
    case (state_q)
      S_DRAIN, S_RELEASE: fetch_suppress = 1'b1;
      S_GRANT: begin
        fetch_suppress = 1'b1;
        ext_grant      = 1'b1;
        ext_ready      = ext_req;
        addr_oe        = 1'b1;
        addr_out       = req_q.addr;
      end
      S_ACCESS: begin
        fetch_suppress = 1'b1;
        ext_grant      = 1'b1;
        addr_oe        = 1'b1;
        addr_out       = req_q.addr;
        mem_load       = 1'b1;
        mem_dir        = ~req_q.write;
        mem_data_oe    = req_q.write;
        mem_wdata      = req_q.wdata;
      end
      default: ;
    endcase
  end

  assign ext_rdata = rdata_q;
  assign ext_done  = done_q;
  assign ext_err   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset state, grant latency,
// a table of directed transactions, a randomized run against a
// transaction-level memory model, request drop / release corner cases and
// reset in the middle of an access.
module tb_mem_bus_arbiter;
  localparam int DC = 3;
  localparam int AT = 15;

  logic        MAINCLK = 1'b0;
  logic        MAINRST = 1'b0;
  logic        ext_req = 1'b0, ext_valid = 1'b0, ext_write = 1'b0;
  logic [15:0] ext_addr = '0;
  logic [7:0]  ext_wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        ext_grant, ext_ready, ext_done, ext_err, fetch_suppress;
  logic        addr_oe, mem_data_oe, mem_load, mem_dir;
  logic [7:0]  ext_rdata, mem_wdata;
  logic [15:0] addr_out;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.DRAIN_CYCLES(DC), .ACK_TIMEOUT(AT)) dut (
    .MAINCLK(MAINCLK), .MAINRST(MAINRST),
    .ext_req(ext_req), .ext_grant(ext_grant), .ext_ready(ext_ready),
    .ext_valid(ext_valid), .ext_write(ext_write), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .ext_err(ext_err), .fetch_suppress(fetch_suppress), .addr_oe(addr_oe),
    .addr_out(addr_out), .mem_data_oe(mem_data_oe), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_load(mem_load), .mem_dir(mem_dir),
    .mem_ack(mem_ack)
  );

  always #5 MAINCLK = ~MAINCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fs"},    fetch_suppress, 0);
    chk({tag, "_grant"}, ext_grant, 0);
    chk({tag, "_ready"}, ext_ready, 0);
    chk({tag, "_aoe"},   addr_oe, 0);
    chk({tag, "_addr"},  addr_out, 0);
    chk({tag, "_load"},  mem_load, 0);
    chk({tag, "_dir"},   mem_dir, 0);
    chk({tag, "_doe"},   mem_data_oe, 0);
    chk({tag, "_wd"},    mem_wdata, 0);
    chk({tag, "_done"},  ext_done, 0);
    chk({tag, "_err"},   ext_err, 0);
  endtask

  task automatic cyc();
    @(posedge MAINCLK);
    @(negedge MAINCLK);
  endtask

  // Called at a negedge; returns at a negedge with the bus granted.
  task automatic get_grant();
    int n;
    ext_req = 1'b1;
    n = 0;
    while (!ext_grant && n < 20) begin cyc(); n++; end
    chk("grant_bound", ext_grant, 1);
  endtask

  // Called at a negedge in a granted, ready cycle. delay = edge after accept
  // at which mem_ack is driven (0 = never). Returns at the negedge where
  // ext_done is seen, ready for a back-to-back transaction.
  task automatic do_txn(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] mrd, input int delay, input bit drop,
                        output int lat, output bit err, output logic [7:0] rd);
    chk("accept_ready", ext_ready, 1);
    ext_valid = 1'b1; ext_write = wr; ext_addr = a; ext_wdata = wd;
    cyc();
    ext_valid = 1'b0; ext_addr = 16'($urandom); ext_wdata = 8'($urandom);
    ext_write = 1'($urandom);
    if (drop) ext_req = 1'b0;
    lat = 0; err = 1'b0; rd = '0;
    for (int k = 1; k <= AT + 5; k++) begin
      chk("acc_load",  mem_load, 1);
      chk("acc_addr",  addr_out, a);
      chk("acc_dir",   mem_dir, !wr);
      chk("acc_doe",   mem_data_oe, wr);
      chk("acc_wdata", mem_wdata, wd);
      chk("acc_ready", ext_ready, 0);
      chk("acc_done",  ext_done, 0);
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? mrd : 8'($urandom);
      cyc();
      mem_ack = 1'b0;
      if (ext_done) begin
        lat = k; err = ext_err; rd = ext_rdata;
        break;
      end
    end
    if (lat == 0) chk("txn_done_bound", 0, 1);
  endtask

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mrd;
    logic [4:0]  delay;
    logic [4:0]  lat;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] mem_model [16];

  initial begin
    int lat;
    bit err;
    logic [7:0] rd, exp_rdata;

    tbl[0] = '{1'b1, 16'h8010, 8'hA5, 8'h00, 5'd2,  5'd2,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 16'h0004, 8'h00, 8'h3C, 5'd1,  5'd1,  1'b0, 8'h3C};
    tbl[2] = '{1'b0, 16'h0005, 8'h00, 8'h77, 5'd15, 5'd15, 1'b0, 8'h77};
    tbl[3] = '{1'b0, 16'h0006, 8'h00, 8'h11, 5'd0,  5'd15, 1'b1, 8'hFF};
    tbl[4] = '{1'b1, 16'h1234, 8'h5A, 8'h00, 5'd0,  5'd15, 1'b1, 8'hFF};
    tbl[5] = '{1'b1, 16'h2000, 8'hC3, 8'h00, 5'd1,  5'd1,  1'b0, 8'hFF};
    tbl[6] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 5'd3,  5'd3,  1'b0, 8'h00};

    // reset state
    #12;
    chk_idle("rst");
    chk("rst_rdata", ext_rdata, 0);
    @(negedge MAINCLK);
    MAINRST = 1'b1;
    cyc();
    chk_idle("post_rst");

    // grant latency: req sampled at edge 0, grant after edge DC
    ext_req = 1'b1;
    for (int i = 0; i <= DC; i++) begin
      cyc();
      chk("lat_fs", fetch_suppress, 1);
      chk("lat_grant", ext_grant, i == DC);
    end
    chk("lat_ready", ext_ready, 1);
    chk("lat_aoe", addr_oe, 1);
    chk("lat_addr0", addr_out, 16'h0000);
    chk("lat_load", mem_load, 0);

    // directed table, each entry starting on the previous done cycle
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mrd, int'(tbl[i].delay),
             1'b0, lat, err, rd);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
    end

    // done is a single pulse; address held; ack outside ACCESS ignored
    mem_ack = 1'b1; mem_rdata = 8'h99;
    cyc();
    chk("pulse_done", ext_done, 0);
    chk("pulse_err", ext_err, 0);
    chk("hold_addr", addr_out, 16'hFFFF);
    chk("hold_rdata", ext_rdata, 8'h00);
    cyc();
    mem_ack = 1'b0;
    chk("stray_ack_done", ext_done, 0);
    chk("stray_ack_load", mem_load, 0);
    chk("stray_ack_grant", ext_grant, 1);

    // randomized transactions against a transaction-level memory model
    for (int i = 0; i < 16; i++) mem_model[i] = 8'($urandom);
    exp_rdata = 8'h00;
    for (int i = 0; i < 40; i++) begin
      bit          wr, ok;
      logic [3:0]  a;
      logic [7:0]  wd;
      int          d, exp_lat;
      wr = 1'($urandom);
      a  = 4'($urandom);
      wd = 8'($urandom);
      d  = $urandom_range(0, AT + 3);
      ok = (d >= 1 && d <= AT);
      exp_lat = ok ? d : AT;
      do_txn(wr, {12'h0A0, a}, wd, mem_model[a], d, 1'b0, lat, err, rd);
      if (!wr) exp_rdata = ok ? mem_model[a] : 8'hFF;
      else if (ok) mem_model[a] = wd;
      chk($sformatf("rnd%0d_lat", i), lat, exp_lat);
      chk($sformatf("rnd%0d_err", i), err, !ok);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rdata);
      if ($urandom_range(0, 3) == 0) cyc();
    end

    // req dropped during ACCESS: access completes, then release
    do_txn(1'b0, 16'h0B00, 8'h00, 8'h5E, 3, 1'b1, lat, err, rd);
    chk("dropacc_lat", lat, 3);
    chk("dropacc_rdata", rd, 8'h5E);
    chk("dropacc_err", err, 0);
    chk("dropacc_grant", ext_grant, 1);
    chk("dropacc_ready", ext_ready, 0);
    cyc();                                 // edge r: GRANT sees req low
    chk("rel_grant", ext_grant, 0);
    chk("rel_aoe", addr_oe, 0);
    chk("rel_fs", fetch_suppress, 1);
    ext_req = 1'b1;                        // ignored in RELEASE
    cyc();
    chk("rel_cpu_fs", fetch_suppress, 0);
    chk("rel_cpu_grant", ext_grant, 0);
    cyc();                                 // CPU samples req high
    chk("resample_fs", fetch_suppress, 1);
    chk("resample_grant", ext_grant, 0);

    // req dropped during DRAIN: no grant, release then CPU
    ext_req = 1'b0;
    cyc();
    chk("dropdrn_grant", ext_grant, 0);
    chk("dropdrn_fs", fetch_suppress, 1);
    cyc();
    chk("dropdrn_cpu_fs", fetch_suppress, 0);
    chk("dropdrn_cpu_grant", ext_grant, 0);
    cyc();
    chk_idle("cpu_idle");

    // reset asserted mid-ACCESS clears outputs at once
    get_grant();
    ext_valid = 1'b1; ext_write = 1'b1; ext_addr = 16'h4444; ext_wdata = 8'h81;
    cyc();
    ext_valid = 1'b0;
    chk("mid_load", mem_load, 1);
    #2 MAINRST = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_rdata", ext_rdata, 0);
    ext_req = 1'b0;
    @(negedge MAINCLK);
    MAINRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("after_rst_fs", fetch_suppress, 0);
      chk("after_rst_grant", ext_grant, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the 16-bit address bus and 8-bit memory data bus between the CPU pipeline and one external bus master (debug loader / UART DMA). On request it suppresses instruction fetch, waits for the pipeline to drain, then grants the bus and sequences single-byte memory reads and writes using the MainMemory load/direction/ack handshake. Sits between the pipeline's FetchSuppress input, the address-bus/MEMDATA drivers and the external master.

## Interface
- DRAIN_CYCLES, 3: cycles between fetch suppression and grant (pipeline depth); legal range 1–15
- ACK_TIMEOUT, 15: max cycles waiting for mem_ack before abort; legal range 1–255
- MAINCLK  in  1  system clock, all state on rising edge
- MAINRST  in  1  reset: asynchronous, active-low
- ext_req  in  1  external master requests bus ownership (level)
- ext_grant  out  1  bus owned by external master
- ext_ready  out  1  arbiter accepts a transaction this cycle
- ext_valid  in  1  transaction request; accepted when ext_valid & ext_ready
- ext_write  in  1  1 = write, 0 = read
- ext_addr  in  16  transaction address
- ext_wdata  in  8  write data
- ext_rdata  out  8  read data, held until next completion
- ext_done  out  1  one-cycle completion pulse
- ext_err  out  1  one-cycle pulse with ext_done on ack timeout
- fetch_suppress  out  1  to Pipeline: stop fetching
- addr_oe  out  1  arbiter drives ADDRBUS
- addr_out  out  16  address driven when addr_oe
- mem_data_oe  out  1  arbiter drives MEMDATA (writes only)
- mem_wdata  out  8  MEMDATA value when mem_data_oe
- mem_rdata  in  8  MEMDATA sampled on reads
- mem_load  out  1  memory strobe (active-high)
- mem_dir  out  1  1 = memory drives MEMDATA, 0 = memory receives
- mem_ack  in  1  memory access complete

## Operation
- States: CPU, DRAIN, GRANT, ACCESS, RELEASE. Reset → CPU.
- CPU: all bus outputs 0. ext_req=1 sampled → DRAIN, counter ← DRAIN_CYCLES−1.
- DRAIN: fetch_suppress=1. Counter decrements; at 0 → GRANT. ext_req=0 sampled → RELEASE (abort, no grant).
- GRANT: fetch_suppress=1, ext_grant=1, addr_oe=1, addr_out = last latched address (0 after reset). ext_ready = ext_req. ext_valid&ext_ready → latch addr/wdata/write, timeout counter ← 0, → ACCESS. ext_req=0 (no valid) → RELEASE.
- ACCESS: mem_load=1; mem_dir = ~write; mem_data_oe = write; mem_wdata = latched wdata; ext_ready=0. mem_ack=1 sampled → capture mem_rdata into ext_rdata (reads only; writes leave ext_rdata unchanged), ext_done=1 next cycle, → GRANT. Counter reaches ACK_TIMEOUT without ack → ext_done=1, ext_err=1, ext_rdata ← 8'hFF (reads only), → GRANT.
- ext_req dropped during ACCESS: access completes normally, then GRANT sees ext_req=0 → RELEASE.
- RELEASE: ext_grant=0, addr_oe=0, mem_* = 0, fetch_suppress=1 for one cycle, → CPU (fetch_suppress=0). ext_req re-asserted during RELEASE ignored; resampled in CPU.
- mem_ack outside ACCESS ignored.

## Timing
- Reset (async, MAINRST=0): state CPU; all outputs 0, ext_rdata=8'h00, addr_out=16'h0000, counters 0.
- ext_req sampled high at edge 0 → fetch_suppress=1 after edge 0; ext_grant=1 after edge DRAIN_CYCLES.
- Accept at edge a; ack sampled at edge a+n (n≥1) → ext_done/ext_rdata valid after edge a+n for one cycle; ext_ready high same cycle. Min throughput: one transaction per 2 cycles.
- Timeout: no ack at edges a+1..a+ACK_TIMEOUT → ext_done+ext_err after edge a+ACK_TIMEOUT. Ack at the timeout edge counts as success.
- Release: ext_req low sampled in GRANT at edge r → ext_grant=0 after r; fetch_suppress=0 after r+1.
- Outputs are registered or decoded from state only; no combinational path from ext_* inputs to memory outputs.

## Test plan
- Reset mid-ACCESS: assert MAINRST=0 → all outputs 0 immediately, state CPU; release reset → fetch_suppress stays 0.
- Grant latency, DRAIN_CYCLES=3: ext_req high at edge 0 → fetch_suppress after edge 0, ext_grant after edge 3, ext_ready=1.
- Write 8'hA5 to 16'h8010, ack 2 cycles after accept → mem_load/mem_data_oe high 2 cycles, mem_dir=0, addr_out=16'h8010, single ext_done, ext_err=0.
- Read 16'h0004 with mem_rdata=8'h3C, ack 1 cycle later → ext_rdata=8'h3C with ext_done; back-to-back second read accepted on done cycle.
- Read with mem_ack never asserted, ACK_TIMEOUT=15 → ext_done+ext_err after 15th edge, ext_rdata=8'hFF, returns to GRANT.
- ext_req dropped during DRAIN and during ACCESS → DRAIN: no grant, RELEASE then CPU; ACCESS: access completes with done, then release, fetch_suppress low 2 edges after req-low sampled in GRANT.
